// File: rtl/wash_pkg.sv
// Shared state encoding and key codes for the wash-cycle sequencer.
package wash_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        FILL  = 3'd2,
        WASH  = 3'd3,
        DRAIN = 3'd4,
        SPIN  = 3'd5,
        PAUSE = 3'd6,
        DONE  = 3'd7
    } wash_state_e;

    localparam logic [2:0] KEY_NONE   = 3'd0;
    localparam logic [2:0] KEY_START  = 3'd1;
    localparam logic [2:0] KEY_LOW    = 3'd2;
    localparam logic [2:0] KEY_HIGH   = 3'd3;
    localparam logic [2:0] KEY_PAUSE  = 3'd4;
    localparam logic [2:0] KEY_RESUME = 3'd5;

    function automatic logic is_timed(wash_state_e s);
        return (s == FILL) || (s == WASH) || (s == DRAIN) || (s == SPIN);
    endfunction

endpackage

// File: rtl/sec_tick.sv
// Seconds prescaler: counts 0..CLK_HZ-1 while enabled and pulses tick on the last count.
module sec_tick #(
    parameter int unsigned CLK_HZ = 20_000_000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    // Holding en low freezes the count, which is how a pause keeps its place.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/wash_ctrl.sv
// Wash-cycle sequencer: key-change events drive fill, wash, drain and spin phases.
module wash_ctrl
    import wash_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 20_000_000,
    parameter int unsigned FILL_LOW_S  = 10,
    parameter int unsigned FILL_HIGH_S = 20,
    parameter int unsigned WASH_S      = 30,
    parameter int unsigned DRAIN_S     = 10,
    parameter int unsigned SPIN_S      = 15,
    parameter int unsigned MOTOR_REV_S = 5
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [2:0] key_value,
    output logic [2:0] state,
    output logic       valve_in,
    output logic       valve_out,
    output logic       motor_on,
    output logic       motor_dir,
    output logic       level_high,
    output logic [7:0] remain_s,
    output logic       done
);

    if (FILL_LOW_S < 1 || FILL_LOW_S > 255 || FILL_HIGH_S < 1 || FILL_HIGH_S > 255 ||
        WASH_S < 1 || WASH_S > 255 || DRAIN_S < 1 || DRAIN_S > 255 ||
        SPIN_S < 1 || SPIN_S > 255 || MOTOR_REV_S < 1 || MOTOR_REV_S > 255 ||
        FILL_HIGH_S < FILL_LOW_S) begin : g_bad_param
        $error("wash_ctrl: durations must be 1..255 and FILL_HIGH_S >= FILL_LOW_S");
    end

    wash_state_e state_q, state_d, resume_q, resume_d;
    logic [2:0]  key_prev_q;
    logic [7:0]  remain_q, remain_d;
    logic [7:0]  rev_q, rev_d;
    logic        level_q, level_d;
    logic        dir_q, dir_d;
    logic [2:0]  ev_code;
    logic        tick, tick_en, tick_clr;

    // A key change is an event carrying the new code; KEY_NONE never acts.
    assign ev_code = (key_value != key_prev_q) ? key_value : KEY_NONE;
    assign tick_en = is_timed(state_q);

    sec_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (tick_clr),
        .en    (tick_en),
        .tick  (tick)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            resume_q   <= IDLE;
            key_prev_q <= KEY_NONE;
            remain_q   <= '0;
            rev_q      <= '0;
            level_q    <= 1'b0;
            dir_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            key_prev_q <= key_value;
            remain_q   <= remain_d;
            rev_q      <= rev_d;
            level_q    <= level_d;
            dir_q      <= dir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        remain_d = remain_q;
        rev_d    = rev_q;
        level_d  = level_q;
        dir_d    = dir_q;
        tick_clr = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (ev_code == KEY_START) state_d = ARMED;
            end
            ARMED: begin
                if (ev_code == KEY_LOW || ev_code == KEY_HIGH) begin
                    state_d  = FILL;
                    level_d  = (ev_code == KEY_HIGH);
                    remain_d = (ev_code == KEY_HIGH) ? 8'(FILL_HIGH_S) : 8'(FILL_LOW_S);
                    tick_clr = 1'b1;
                end
            end
            PAUSE: begin
                if (ev_code == KEY_RESUME) state_d = resume_q;
            end
            FILL, WASH, DRAIN, SPIN: begin
                // Pause and level upgrade both swallow a coincident tick.
                if (ev_code == KEY_PAUSE) begin
                    resume_d = state_q;
                    state_d  = PAUSE;
                end else if (state_q == FILL && ev_code == KEY_HIGH && !level_q) begin
                    level_d  = 1'b1;
                    remain_d = remain_q + 8'(FILL_HIGH_S - FILL_LOW_S);
                end else if (tick) begin
                    if (remain_q == 8'd1) begin
                        tick_clr = 1'b1;
                        case (state_q)
                            FILL: begin
                                state_d  = WASH;
                                remain_d = 8'(WASH_S);
                                rev_d    = '0;
                                dir_d    = 1'b0;
                            end
                            WASH: begin
                                state_d  = DRAIN;
                                remain_d = 8'(DRAIN_S);
                            end
                            DRAIN: begin
                                state_d  = SPIN;
                                remain_d = 8'(SPIN_S);
                            end
                            default: begin
                                state_d  = DONE;
                                remain_d = '0;
                            end
                        endcase
                    end else begin
                        remain_d = remain_q - 8'd1;
                        if (state_q == WASH) begin
                            if (rev_q + 8'd1 == 8'(MOTOR_REV_S)) begin
                                rev_d = '0;
                                dir_d = ~dir_q;
                            end else begin
                                rev_d = rev_q + 8'd1;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        state      = state_q;
        valve_in   = (state_q == FILL);
        valve_out  = (state_q == DRAIN) || (state_q == SPIN);
        motor_on   = (state_q == WASH) || (state_q == SPIN);
        motor_dir  = (state_q == WASH) && dir_q;
        level_high = level_q;
        remain_s   = remain_q;
        done       = (state_q == DONE);
    end

endmodule

// File: tb/tb_wash_ctrl.sv
// Self-checking bench for wash_ctrl: directed scenarios plus random keys against a reference model.
module tb_wash_ctrl;

    localparam int CLK_HZ = 10;
    localparam int FL = 2;
    localparam int FH = 4;
    localparam int WS = 6;
    localparam int DS = 2;
    localparam int SS = 3;
    localparam int MR = 2;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [2:0] key_value = 3'd0;
    logic [2:0] state;
    logic       valve_in, valve_out, motor_on, motor_dir, level_high, done;
    logic [7:0] remain_s;

    wash_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .FILL_LOW_S  (FL),
        .FILL_HIGH_S (FH),
        .WASH_S      (WS),
        .DRAIN_S     (DS),
        .SPIN_S      (SS),
        .MOTOR_REV_S (MR)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .key_value  (key_value),
        .state      (state),
        .valve_in   (valve_in),
        .valve_out  (valve_out),
        .motor_on   (motor_on),
        .motor_dir  (motor_dir),
        .level_high (level_high),
        .remain_s   (remain_s),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Reference model: states by number (0 idle .. 7 done), seconds and cycles-into-second.
    int         m_st = 0;
    int         m_rem = 0;
    int         m_sub = 0;
    int         m_res = 0;
    bit         m_lvl = 1'b0;
    logic [2:0] m_prev = 3'd0;

    function automatic int next_of(input int s);
        case (s)
            2: return 3;
            3: return 4;
            4: return 5;
            default: return 7;
        endcase
    endfunction

    function automatic int dur_of(input int s);
        case (s)
            3: return WS;
            4: return DS;
            5: return SS;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input logic [2:0] k);
        bit ev;
        bit tk;
        ev = (k != m_prev);
        m_prev = k;
        case (m_st)
            0, 7: if (ev && k == 3'd1) m_st = 1;
            1: begin
                if (ev && (k == 3'd2 || k == 3'd3)) begin
                    m_st = 2;
                    m_lvl = (k == 3'd3);
                    m_rem = (k == 3'd3) ? FH : FL;
                    m_sub = 0;
                end
            end
            6: if (ev && k == 3'd5) m_st = m_res;
            default: begin
                tk = (m_sub == CLK_HZ - 1);
                m_sub = tk ? 0 : m_sub + 1;
                if (ev && k == 3'd4) begin
                    m_res = m_st;
                    m_st = 6;
                end else if (m_st == 2 && ev && k == 3'd3 && !m_lvl) begin
                    m_lvl = 1'b1;
                    m_rem = m_rem + FH - FL;
                end else if (tk) begin
                    if (m_rem == 1) begin
                        m_st = next_of(m_st);
                        m_rem = dur_of(m_st);
                        m_sub = 0;
                    end else begin
                        m_rem = m_rem - 1;
                    end
                end
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                m_st = 0; m_rem = 0; m_sub = 0; m_res = 0; m_lvl = 1'b0; m_prev = 3'd0;
            end else begin
                model_step(key_value);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: DUT outputs against the model, motor direction from elapsed wash seconds.
    initial begin
        forever begin
            @(negedge CLK);
            if (cmp_en) begin
                chk("model state", int'(state), m_st);
                chk("model valve_in", int'(valve_in), int'(m_st == 2));
                chk("model valve_out", int'(valve_out), int'(m_st == 4 || m_st == 5));
                chk("model motor_on", int'(motor_on), int'(m_st == 3 || m_st == 5));
                chk("model motor_dir", int'(motor_dir), (m_st == 3) ? ((WS - m_rem) / MR) % 2 : 0);
                chk("model level_high", int'(level_high), int'(m_lvl));
                chk("model remain_s", int'(remain_s), m_rem);
                chk("model done", int'(done), int'(m_st == 7));
            end
        end
    end

    task automatic press(input logic [2:0] k);
        key_value = k;
        @(negedge CLK);
    endtask

    task automatic wait_state(input int target, input int limit, output int n);
        n = 0;
        while (int'(state) != target && n < limit) begin
            @(negedge CLK);
            n++;
        end
        if (int'(state) != target) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_state: state %0d, expected %0d within %0d cycles",
                     state, target, limit);
        end
    endtask

    function automatic int all_outs();
        return int'({state, valve_in, valve_out, motor_on, motor_dir, level_high, remain_s, done});
    endfunction

    initial begin
        int n;
        repeat (3) @(negedge CLK);
        cmp_en = 1'b1;
        chk("reset outputs", all_outs(), 0);
        RST_N = 1'b1;
        @(negedge CLK);

        // Full low-level run.
        press(3'd1);
        chk("armed", int'(state), 1);
        press(3'd2);
        chk("fill state", int'(state), 2);
        chk("fill remain", int'(remain_s), 2);
        chk("fill valve_in", int'(valve_in), 1);
        wait_state(3, 200, n);
        chk("fill->wash cycles", n, 20);
        repeat (19) @(negedge CLK);
        chk("dir before 2s", int'(motor_dir), 0);
        @(negedge CLK);
        chk("dir at 2s", int'(motor_dir), 1);
        wait_state(4, 200, n);
        chk("wash->drain cycles", n, 40);
        wait_state(5, 200, n);
        chk("drain->spin cycles", n, 20);
        wait_state(7, 200, n);
        chk("spin->done cycles", n, 30);
        chk("done flag", int'(done), 1);

        // Restart from DONE, then level upgrade.
        press(3'd1);
        chk("done->armed", int'(state), 1);
        chk("done cleared", int'(done), 0);
        press(3'd2);
        repeat (10) @(negedge CLK);
        chk("remain before upgrade", int'(remain_s), 1);
        press(3'd3);
        chk("remain after upgrade", int'(remain_s), 3);
        chk("level after upgrade", int'(level_high), 1);
        wait_state(3, 200, n);
        chk("upgrade->wash cycles", n, 29);

        // Pause and resume mid-wash.
        repeat (24) @(negedge CLK);
        press(3'd4);
        chk("pause state", int'(state), 6);
        chk("pause remain", int'(remain_s), 4);
        chk("pause actuators", int'({valve_in, valve_out, motor_on, motor_dir}), 0);
        repeat (49) @(negedge CLK);
        chk("remain frozen", int'(remain_s), 4);
        press(3'd5);
        chk("resume state", int'(state), 3);
        chk("resume dir", int'(motor_dir), 1);
        wait_state(4, 200, n);
        chk("resume->drain cycles", n, 35);

        // Pause on the tick cycle in DRAIN.
        repeat (9) @(negedge CLK);
        press(3'd4);
        chk("tick+pause state", int'(state), 6);
        chk("tick+pause remain", int'(remain_s), 2);
        press(3'd5);
        wait_state(5, 200, n);
        chk("resume->spin cycles", n, 20);

        // Ignored events in SPIN and DONE.
        repeat (5) @(negedge CLK);
        press(3'd1);
        chk("start ignored in spin", int'(state), 5);
        wait_state(7, 200, n);
        chk("spin rest cycles", n, 24);
        press(3'd4);
        chk("pause ignored in done", int'(state), 7);
        press(3'd1);
        chk("done->armed again", int'(state), 1);

        // Asynchronous reset in the middle of FILL.
        press(3'd2);
        repeat (5) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1 chk("async reset outputs", all_outs(), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("level key ignored in idle", int'(state), 0);
        press(3'd1);
        press(3'd3);
        chk("high fill state", int'(state), 2);
        chk("high fill remain", int'(remain_s), 4);

        // Random keys, holds and occasional resets against the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                #2 RST_N = 1'b0;
                @(negedge CLK);
                RST_N = 1'b1;
            end
            key_value = 3'($urandom_range(0, 5));
            repeat ($urandom_range(1, 40)) @(negedge CLK);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_ctrl.md
# wash_ctrl

Wash-cycle sequencer for the washing-machine design; sits directly downstream of the key scanner and consumes its 3-bit key code. Each key-code change drives a timed state machine: fill, wash with motor reversal, drain, spin, done. It also supports pause/resume and outputs the actuator enables plus a seconds-remaining count for the display stage.

## Interface
- CLK_HZ, 20_000_000, clock cycles per second tick; set small in simulation.
- FILL_LOW_S, 10, fill time at low water level, seconds.
- FILL_HIGH_S, 20, fill time at high water level, seconds; must be ≥ FILL_LOW_S.
- WASH_S, 30, wash time, seconds.
- DRAIN_S, 10, drain time, seconds.
- SPIN_S, 15, spin time, seconds.
- MOTOR_REV_S, 5, seconds between motor direction reversals in WASH.
- CLK  in  1  system clock, 20 MHz; one clock domain.
- RST_N  in  1  asynchronous, active-low reset.
- key_value  in  3  key code from the scanner: 0 none, 1 start, 2 water low, 3 water high, 4 pause, 5 resume.
- state  out  3  current FSM state (package encoding).
- valve_in  out  1  inlet valve enable.
- valve_out  out  1  drain valve enable.
- motor_on  out  1  motor enable.
- motor_dir  out  1  motor direction; 0 forward, 1 reverse.
- level_high  out  1  selected water level.
- remain_s  out  8  seconds remaining in the current timed state.
- done  out  1  cycle complete.

## Operation
- Reset:
  - state=IDLE; every other output is 0; key_prev=0.
  - The prescaler and reversal counter are cleared.
- Event detection:
  - key_prev registers key_value every cycle.
  - ev = (key_value != key_prev); the code of the event is key_value.
- States: IDLE, ARMED, FILL, WASH, DRAIN, SPIN, PAUSE, DONE.
- IDLE or DONE, ev=1: go to ARMED and clear done.
- ARMED:
  - ev=2: go to FILL with level_high=0, remain=FILL_LOW_S.
  - ev=3: go to FILL with level_high=1, remain=FILL_HIGH_S.
- FILL, ev=3 while level_high=0: set level_high=1 and add remain += FILL_HIGH_S−FILL_LOW_S. There is no state change.
- Timed states (FILL, WASH, DRAIN, SPIN): remain decrements on each tick. A tick with remain==1 transitions and loads the next duration:
  - FILL→WASH (WASH_S)
  - WASH→DRAIN (DRAIN_S)
  - DRAIN→SPIN (SPIN_S)
  - SPIN→DONE (remain=0)
- Actuator outputs by state:
  - FILL: valve_in=1.
  - WASH: motor_on=1; motor_dir toggles every MOTOR_REV_S ticks, starting at 0 on WASH entry.
  - DRAIN: valve_out=1.
  - SPIN: valve_out=1, motor_on=1, motor_dir=0.
  - DONE: done=1.
  - PAUSE, IDLE, ARMED: all actuators 0.
- Pause and resume:
  - ev=4 in a timed state: save the state into resume_st and go to PAUSE. remain, the prescaler count, motor_dir and the reversal count are frozen.
  - ev=5 in PAUSE: return to resume_st and continue from the frozen values.
- Every event not listed above is ignored and leaves the state unchanged. This includes ev=1 while running or paused, ev=4 in DONE, and ev=0.

## Timing
- Event latency: outputs change on the first CLK edge after key_value changes. That edge both updates state and captures key_prev.
- Tick:
  - The prescaler counts 0..CLK_HZ−1 and asserts a 1-cycle tick at CLK_HZ−1.
  - It is cleared on entry to every timed state except a resume, so the first second after entry is full length.
- Simultaneous events:
  - ev=4 in the same cycle as a tick: the pause wins and the tick is discarded; remain is unchanged.
  - ev=3 level upgrade in the same cycle as a tick: the upgrade wins and the tick is discarded. A FILL transition at remain==1 therefore does not occur in that cycle.
- Width: remain_s is 8-bit unsigned. Every duration parameter must be 1..255; this is checked by an elaboration assertion.
- Reset asserted mid-cycle: everything returns to its reset values immediately and asynchronously.

## Structure
- Package wash_pkg holds:
  - the state enum, 3-bit encoding: IDLE=0, ARMED=1, FILL=2, WASH=3, DRAIN=4, SPIN=5, PAUSE=6, DONE=7;
  - the key-code constants KEY_NONE..KEY_RESUME.
- Sub-module sec_tick: a prescaler with CLK, RST_N, clr, en and tick ports, parameter CLK_HZ.
- The top level holds the FSM, remain, resume_st and the reversal counter.

## Test plan
Parameters for all scenarios: CLK_HZ=10, FILL_LOW_S=2, FILL_HIGH_S=4, WASH_S=6, DRAIN_S=2, SPIN_S=3, MOTOR_REV_S=2.
- Full low-level run: key 0→1→2. Expected: FILL with remain=2 → WASH after 20 cycles → DRAIN after a further 60 → SPIN after 20 → DONE after 30, with done=1. motor_dir must toggle at WASH seconds 2 and 4.
- Level upgrade: key 1→2, wait 1 s, then 2→3. Expected: remain goes 1→3, level_high=1, and WASH is entered 3 s later.
- Pause/resume in WASH: 4 at remain=4 plus 5 prescaler cycles, hold 50 cycles, then 5. Expected: actuators 0 during PAUSE, all frozen values unchanged, and the remaining time resumes exactly (total wash time = 60 + 50 cycles).
- Tick and pause in the same cycle: pause applied on the tick cycle. Expected: remain is not decremented; state=PAUSE.
- Ignored events: key 1 during SPIN, and 4 in DONE. Expected: no state change. A later 1 from DONE goes to ARMED with done=0.
- Reset mid-FILL: drop RST_N. Expected: state=IDLE with every output 0 within the same cycle; after release, the key path behaves normally.
